// File: rtl/cmp_pkg.sv
// Shared types and default widths for the time-multiplexed compare unit.
package cmp_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefTagW  = 5;

  typedef struct packed {
    logic [DefWidth-1:0] a;
    logic [DefWidth-1:0] b;
    logic                is_unsigned;
    logic [DefTagW-1:0]  tag;
    logic                id;
  } cmp_req_t;

  typedef struct packed {
    logic               lt;
    logic               eq;
    logic [DefTagW-1:0] tag;
    logic               id;
  } cmp_rsp_t;

endpackage

// File: rtl/cmp_arbiter_if.sv
// Request/response bundle between the two requesters, the consumer and the compare unit.
interface cmp_arbiter_if
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned TAGW  = DefTagW
);

  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic [1:0]         req_unsigned;
  logic [2*TAGW-1:0]  req_tag;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [TAGW-1:0]    rsp_tag;
  logic               rsp_lt;
  logic               rsp_eq;

  modport master (
    output req_valid, req_a, req_b, req_unsigned, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_tag, rsp_lt, rsp_eq
  );

  modport slave (
    input  req_valid, req_a, req_b, req_unsigned, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_tag, rsp_lt, rsp_eq
  );

endinterface

// File: rtl/cmp_flag_gen.sv
// Combinational a-b flag generation (N, V, C, Z) feeding the shared comparator.
module cmp_flag_gen
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_unsigned,
  output logic             o_lt,
  output logic             o_eq
);

  logic [WIDTH:0] w_diff;
  logic           w_n;
  logic           w_v;
  logic           w_c;

  // Carry out of a + ~b + 1 is set exactly when a >= b unsigned.
  assign w_diff = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_c    = w_diff[WIDTH];
  assign w_n    = w_diff[WIDTH-1];
  assign w_v    = (i_a[WIDTH-1] ^ i_b[WIDTH-1]) & (i_a[WIDTH-1] ^ w_n);
  assign o_eq   = (w_diff[WIDTH-1:0] == '0);

  comparator u_comparator (
    .i_flag_n (w_n),
    .i_flag_v (w_v),
    .i_flag_c (w_c),
    .i_bool0  (i_unsigned),
    .o_lt     (o_lt)
  );

endmodule

// File: rtl/comparator.sv
// Resolves less-than from subtract flags; bool0 selects unsigned (carry) or signed (N^V).
module comparator (
  input  logic i_flag_n,
  input  logic i_flag_v,
  input  logic i_flag_c,
  input  logic i_bool0,
  output logic o_lt
);

  assign o_lt = i_bool0 ? ~i_flag_c : (i_flag_n ^ i_flag_v);

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter for two compare requesters feeding a 2-stage elastic compare pipeline.
module cmp_arbiter
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned TAGW  = DefTagW
) (
  input logic          clk,
  input logic          rst_n,
  cmp_arbiter_if.slave bus
);

  logic [1:0] w_grant;
  logic       w_s1_adv;
  logic       w_s2_adv;
  logic       w_accept;
  logic       w_sel;
  logic       w_lt;
  logic       w_eq;
  cmp_req_t   w_s1_d;
  cmp_req_t   r_s1;
  cmp_rsp_t   r_s2;
  logic       r_s1_valid;
  logic       r_s2_valid;
  logic       r_rr_ptr;

  assign w_s2_adv = ~r_s2_valid | bus.rsp_ready;
  assign w_s1_adv = ~r_s1_valid | w_s2_adv;

  // r_rr_ptr names the requester that wins a tie.
  always_comb begin
    w_grant = 2'b00;
    case (bus.req_valid)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = r_rr_ptr ? 2'b10 : 2'b01;
      default: w_grant = 2'b00;
    endcase
  end

  assign bus.req_ready = w_grant & {2{w_s1_adv}};
  assign w_accept      = |bus.req_ready;
  assign w_sel         = w_grant[1];

  always_comb begin
    w_s1_d             = '0;
    w_s1_d.a           = w_sel ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
    w_s1_d.b           = w_sel ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
    w_s1_d.is_unsigned = bus.req_unsigned[w_sel];
    w_s1_d.tag         = w_sel ? bus.req_tag[2*TAGW-1:TAGW] : bus.req_tag[TAGW-1:0];
    w_s1_d.id          = w_sel;
  end

  cmp_flag_gen #(
    .WIDTH (WIDTH)
  ) u_flag_gen (
    .i_a        (r_s1.a),
    .i_b        (r_s1.b),
    .i_unsigned (r_s1.is_unsigned),
    .o_lt       (w_lt),
    .o_eq       (w_eq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
      r_s2_valid <= 1'b0;
      r_s2       <= '0;
      r_rr_ptr   <= 1'b0;
    end else begin
      if (w_accept) r_rr_ptr <= ~w_sel;
      if (w_s1_adv) begin
        r_s1_valid <= w_accept;
        if (w_accept) r_s1 <= w_s1_d;
      end
      // Result fields only move with real data so outputs never change under a bubble.
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2.lt  <= w_lt;
          r_s2.eq  <= w_eq;
          r_s2.tag <= r_s1.tag;
          r_s2.id  <= r_s1.id;
        end
      end
    end
  end

  assign bus.rsp_valid = r_s2_valid;
  assign bus.rsp_id    = r_s2.id;
  assign bus.rsp_tag   = r_s2.tag;
  assign bus.rsp_lt    = r_s2.lt;
  assign bus.rsp_eq    = r_s2.eq;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed vectors, multi-cycle sequences and a random stress run for cmp_arbiter.
module tb_cmp_arbiter;
  import cmp_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned TW = 5;

  typedef logic [7:0] rsp_t;  // {id, tag, lt, eq}

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        uns;
    logic        lt;
    logic        eq;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmp_arbiter_if #(.WIDTH(W), .TAGW(TW)) bus ();

  cmp_arbiter #(
    .WIDTH (W),
    .TAGW  (TW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned n_acc = 0;
  int unsigned acc_cnt [2];
  int unsigned rsp_cnt [2];
  rsp_t        exp_q [$];
  vec_t        vecs [10];

  function automatic logic model_lt(input logic [31:0] a, input logic [31:0] b, input logic uns);
    return uns ? (a < b) : ($signed(a) < $signed(b));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic present(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic uns, input logic [4:0] tag);
    bus.req_a[i*W +: W]    = a;
    bus.req_b[i*W +: W]    = b;
    bus.req_unsigned[i]    = uns;
    bus.req_tag[i*TW +: TW] = tag;
    bus.req_valid[i]       = 1'b1;
  endtask

  // Entered 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic tick(input bit do_rdy, input logic [1:0] exp_rdy);
    logic [1:0]  acc;
    logic [31:0] a;
    logic [31:0] b;
    #1;
    if (do_rdy) chk("grant", bus.req_ready, exp_rdy);
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_rsp: got id %0d tag %0h expected no response",
                 bus.rsp_id, bus.rsp_tag);
      end else begin
        chk("rsp", {bus.rsp_id, bus.rsp_tag, bus.rsp_lt, bus.rsp_eq}, exp_q.pop_front());
        rsp_cnt[bus.rsp_id]++;
      end
    end
    acc = bus.req_valid & bus.req_ready;
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        a = bus.req_a[i*W +: W];
        b = bus.req_b[i*W +: W];
        exp_q.push_back({i[0], bus.req_tag[i*TW +: TW], model_lt(a, b, bus.req_unsigned[i]),
                         (a == b)});
        acc_cnt[i]++;
        n_acc++;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) if (acc[i]) bus.req_valid[i] = 1'b0;
  endtask

  initial begin
    logic [31:0] spec_v [4];
    logic [4:0]  tg [2];
    logic [31:0] a;
    logic [31:0] b;
    int          id;
    bit          c_sent;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
    vecs[9] = '{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
    spec_v  = '{32'h0, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};

    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0;
    bus.req_unsigned = '0; bus.req_tag = '0; bus.rsp_ready = 1'b1;

    // Reset state, plus single-requester grant while held in reset.
    #12;
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_fields", {bus.rsp_id, bus.rsp_tag, bus.rsp_lt, bus.rsp_eq}, 8'h00);
    chk("rst_ready_idle", bus.req_ready, 2'b00);
    bus.req_valid = 2'b10;
    #1;
    chk("rst_ready_single", bus.req_ready, 2'b10);
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven single transactions with latency check.
    for (int k = 0; k < 10; k++) begin
      id = k % 2;
      present(id, vecs[k].a, vecs[k].b, vecs[k].uns, 5'(k + 3));
      #1;
      chk("vec_ready", bus.req_ready, (id == 1) ? 2'b10 : 2'b01);
      @(posedge clk);
      #1;
      bus.req_valid[id] = 1'b0;
      #1;
      chk("vec_lat1", bus.rsp_valid, 1'b0);
      @(posedge clk);
      #1;
      chk("vec_valid", bus.rsp_valid, 1'b1);
      chk("vec_rsp", {bus.rsp_id, bus.rsp_tag, bus.rsp_lt, bus.rsp_eq},
          {id[0], 5'(k + 3), vecs[k].lt, vecs[k].eq});
      @(posedge clk);
      #1;
      chk("vec_drain", bus.rsp_valid, 1'b0);
    end

    // Mid-flight reset with both stages occupied.
    bus.rsp_ready = 1'b0;
    present(0, 32'h5, 32'h6, 1'b0, 5'h1);
    present(1, 32'h7, 32'h6, 1'b1, 5'h2);
    tick(1'b0, 2'b00);
    tick(1'b0, 2'b00);
    chk("mid_full", bus.rsp_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_async", bus.rsp_valid, 1'b0);
    exp_q.delete();
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 2'b00);
      chk("mid_no_stale", bus.rsp_valid, 1'b0);
    end

    // Contention from reset: grants alternate starting with requester 0.
    tg = '{5'h00, 5'h10};
    for (int i = 0; i < 2; i++) begin
      present(i, 32'(i * 3), 32'h2, i[0], tg[i]);
      tg[i]++;
    end
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, (k % 2 == 0) ? 2'b01 : 2'b10);
      for (int i = 0; i < 2; i++) begin
        if (!bus.req_valid[i]) begin
          present(i, 32'hFFFF_FFF0 + 32'(k), 32'(k * 5), i[0], tg[i]);
          tg[i]++;
        end
      end
    end
    bus.req_valid = 2'b00;
    for (int k = 0; k < 3; k++) tick(1'b0, 2'b00);
    chk("cont_drained", exp_q.size(), 0);

    // Backpressure: three requests against a stalled consumer.
    bus.rsp_ready = 1'b0;
    n_acc  = 0;
    c_sent = 1'b0;
    present(0, 32'h8000_0000, 32'h1, 1'b0, 5'h0A);
    present(1, 32'h3, 32'h3, 1'b1, 5'h0B);
    for (int k = 0; k < 4; k++) begin
      tick(k >= 2, 2'b00);
      if (!c_sent && !bus.req_valid[0]) begin
        present(0, 32'h1, 32'hFFFF_FFFF, 1'b1, 5'h0C);
        c_sent = 1'b1;
      end
      if (k >= 1) chk("bp_hold", {bus.rsp_valid, bus.rsp_id, bus.rsp_tag, bus.rsp_lt, bus.rsp_eq},
                      {1'b1, exp_q[0]});
    end
    chk("bp_accepted", n_acc, 2);
    bus.rsp_ready = 1'b1;
    tick(1'b1, 2'b01);
    for (int k = 0; k < 4; k++) tick(1'b0, 2'b00);
    chk("bp_total", n_acc, 3);
    chk("bp_drained", exp_q.size(), 0);

    // Random stress against the reference model.
    acc_cnt = '{0, 0};
    rsp_cnt = '{0, 0};
    for (int k = 0; k < 10000; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!bus.req_valid[i] && ($urandom_range(0, 2) != 0)) begin
          a = ($urandom_range(0, 2) == 0) ? spec_v[$urandom_range(0, 3)] : $urandom;
          b = ($urandom_range(0, 2) == 0) ? spec_v[$urandom_range(0, 3)] : $urandom;
          if ($urandom_range(0, 7) == 0) b = a;
          present(i, a, b, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      tick(1'b0, 2'b00);
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick(1'b0, 2'b00);
    chk("stress_drained", exp_q.size(), 0);
    chk("stress_count0", rsp_cnt[0], acc_cnt[0]);
    chk("stress_count1", rsp_cnt[1], acc_cnt[1]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cmp_arbiter.md
Name: cmp_arbiter

Overview:
- Shared compare unit (subtract plus less-than/equal resolution) time-multiplexed between two requesters: requester 0 is execute-stage SLT/SLTU, requester 1 is the branch-resolution unit.
- Round-robin arbitration feeds a 2-stage elastic pipeline: stage 1 latches the operands, stage 2 computes flags and latches the result.
- Sustains one compare per cycle. Latency is 2 cycles from acceptance to rsp_valid.

Parameters:
- WIDTH, 32, operand width in bits.
- TAGW, 5, width of the opaque tag returned with each result (destination register or branch ID).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept; a transfer occurs when valid and ready are both high.
- req_a  in  2*WIDTH  operand A; requester i uses slice [i*WIDTH +: WIDTH].
- req_b  in  2*WIDTH  operand B, same slicing as req_a.
- req_unsigned  in  2  1 selects unsigned compare (SLTU), 0 selects signed (SLT).
- req_tag  in  2*TAGW  opaque tag per requester.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_id  out  1  index of the requester that owns the result.
- rsp_tag  out  TAGW  echoed tag.
- rsp_lt  out  1  A < B under the selected signedness.
- rsp_eq  out  1  A == B.

Behaviour:
- Reset (async, rst_n low): s1_valid=0, s2_valid=0, rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_lt=0, rsp_eq=0, rr_ptr=0 (requester 0 has priority first). Reset mid-operation discards all in-flight compares with no response.
- Pipeline advance rules:
  - s2_adv = ~s2_valid | rsp_ready.
  - s1_adv = ~s1_valid | s2_adv.
- Arbitration is combinational:
  - If only one requester is valid, it is granted.
  - If both are valid, rr_ptr's requester is granted.
  - req_ready[i] = grant[i] & s1_adv. The ungranted requester sees ready=0.
- On acceptance from requester i: rr_ptr <= ~i. No acceptance leaves rr_ptr unchanged.
- Stage 1 captures a, b, unsigned, tag and id on acceptance. If s1_adv is true with no acceptance, s1_valid <= 0.
- Stage 2 flags, computed from stage-1 contents in WIDTH+1-bit arithmetic:
  - diff = a + ~b + 1.
  - C = diff[WIDTH].
  - N = diff[WIDTH-1].
  - V = (a[MSB]^b[MSB]) & (a[MSB]^N).
  - Z = (diff[WIDTH-1:0]==0).
- lt = unsigned ? ~C : (N ^ V). Produced by instantiating the existing comparator block (FlagN=N, FlagV=V, FlagC=C, bool0=unsigned). eq = Z.
- On s2_adv, stage 2 registers load from stage 1 (s2_valid <= s1_valid).
- Result hold: when rsp_valid=1 and rsp_ready=0, all rsp_* outputs hold stable.
- Latency and throughput:
  - A request accepted at edge N gives rsp_valid at edge N+2 when rsp_ready is held high.
  - Back-to-back acceptance every cycle.
- Full pipeline: both stages valid and rsp_ready=0 forces req_ready=00. When rsp_ready rises, the same cycle allows a new acceptance (no bubble).
- Wrap-around and boundary values: 0x80000000 vs 0x7FFFFFFF yields signed lt=1 (V=1) and unsigned lt=0. A==B yields lt=0, eq=1, C=1 in both modes.
- Requester obligation: hold req_valid and its data stable until ready. The arbiter never drops a presented request.

Decomposition:
- Shared package cmp_pkg holds:
  - the WIDTH and TAGW defaults;
  - a packed struct cmp_req_t {a, b, unsigned, tag, id} used for the stage-1 register;
  - a packed struct cmp_rsp_t {lt, eq, tag, id} for the stage-2 register.
- One sub-module, cmp_flag_gen: combinational, computes N, V, C, Z from a and b and instantiates comparator.
- Arbitration and the pipeline registers stay in cmp_arbiter.

Test Plan:
- Single signed request: req 0, a=0xFFFFFFFF, b=0x00000001, unsigned=0, tag=3, accepted at cycle 0 -> cycle 2 shows rsp_valid=1, id=0, tag=3, lt=1, eq=0. With unsigned=1 -> lt=0.
- Overflow boundary: a=0x80000000, b=0x7FFFFFFF -> signed lt=1, unsigned lt=0. Then a=b=0x12345678 -> lt=0, eq=1 in both modes.
- Contention: both requesters valid continuously from reset -> grants alternate 0,1,0,1. Responses return in acceptance order, one per cycle, with correct id and tag.
- Backpressure: rsp_ready=0 for 4 cycles with 3 requests queued -> exactly 2 accepted, req_ready=00 afterwards, and rsp_* stable. rsp_ready=1 -> the remaining request is accepted in the same cycle, with no loss or duplication.
- Mid-flight reset: rst_n pulled low while both stages are valid -> rsp_valid=0 immediately (async) and rr_ptr=0. After release, no stale response ever appears.
- Randomised stress against a reference model: 10k random operands, signedness and handshake patterns -> every lt/eq matches the model and request and response counts per requester are equal.
